ysyx_24110006_axi_rd_slave: RTL

//  AXI4 read-channel responder (AR/R) backed by an internal word-addressed memory. Serves fetch

---
 rtl/ysyx_24110006_axi_rd_slave.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/ysyx_24110006_axi_rd_slave.sv
// AXI4 read-only slave (AR/R) serving INCR/FIXED bursts from a word-addressed memory.
// Optional macro RAND_DELAY_EN adds LFSR-driven arready hold-off and inter-beat rvalid gaps.
module ysyx_24110006_axi_rd_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 2,
  parameter string       INIT_FILE = ""
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic [31:0] i_axi_araddr,
  input  logic        i_axi_arvalid,
  output logic        o_axi_arready,
  input  logic [3:0]  i_axi_arid,
  input  logic [7:0]  i_axi_arlen,
  input  logic [2:0]  i_axi_arsize,
  input  logic [1:0]  i_axi_arburst,
  output logic [31:0] o_axi_rdata,
  output logic        o_axi_rvalid,
  input  logic        i_axi_rready,
  output logic [1:0]  o_axi_rresp,
  output logic [3:0]  o_axi_rid,
  output logic        o_axi_rlast,
  output logic [1:0]  o_dbg_state
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_DATA = 2'd2, S_GAP = 2'd3} state_t;

  logic [31:0] mem_q [DEPTH];

  state_t      state_q;
  logic [31:0] cur_addr_q;
  logic [7:0]  len_q;
  logic [7:0]  beat_cnt_q;
  logic [7:0]  wait_cnt_q;
  logic        bad_q;
  logic        fixed_q;
  logic        rvalid_q;
  logic        rlast_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;
  logic [3:0]  rid_q;
`ifdef RAND_DELAY_EN
  logic [7:0]  lfsr_q;
  logic [1:0]  hold_q;
  logic [1:0]  gap_q;
`endif

  logic        ar_hs_w;
  logic        load_w;
  logic [31:0] off_w;
  logic [29:0] word_off_w;
  logic        in_range_w;
  logic [31:0] beat_data_w;
  logic [1:0]  beat_resp_w;
  logic [31:0] next_addr_w;
  logic        unused_off_bits;

  // Handshakes: a transfer happens on a rising edge where valid && ready; the slave holds
  // rdata/rresp/rid/rlast stable while rvalid && !rready, and never waits on rready to raise rvalid.
`ifdef RAND_DELAY_EN
  assign o_axi_arready = (state_q == S_IDLE) && !i_reset && (hold_q == 2'd0);
`else
  assign o_axi_arready = (state_q == S_IDLE) && !i_reset;
`endif
  assign ar_hs_w = i_axi_arvalid && o_axi_arready;

  // Decode of the beat about to be presented; size/burst errors take priority over range errors.
  always_comb begin
    off_w       = cur_addr_q - BASE_ADDR;
    word_off_w  = off_w[31:2];
    in_range_w  = (cur_addr_q >= BASE_ADDR) && (word_off_w < 30'(DEPTH));
    beat_data_w = 32'h0;
    beat_resp_w = RESP_OKAY;
    if (bad_q)            beat_resp_w = RESP_SLVERR;
    else if (!in_range_w) beat_resp_w = RESP_DECERR;
    else                  beat_data_w = mem_q[word_off_w[AW-1:0]];
    next_addr_w = fixed_q ? cur_addr_q : cur_addr_q + 32'd4;
  end
  assign unused_off_bits = ^off_w[1:0];

  always_comb begin
    load_w = 1'b0;
    case (state_q)
      S_WAIT: load_w = (wait_cnt_q == 8'd0);
`ifdef RAND_DELAY_EN
      S_DATA: load_w = rvalid_q && i_axi_rready && !rlast_q && (lfsr_q[1:0] == 2'd0);
      S_GAP:  load_w = (gap_q == 2'd0);
`else
      S_DATA: load_w = rvalid_q && i_axi_rready && !rlast_q;
`endif
      default: load_w = 1'b0;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      cur_addr_q <= 32'h0;
      len_q      <= 8'h0;
      beat_cnt_q <= 8'h0;
      wait_cnt_q <= 8'h0;
      bad_q      <= 1'b0;
      fixed_q    <= 1'b0;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      rdata_q    <= 32'h0;
      rresp_q    <= 2'b00;
      rid_q      <= 4'h0;
`ifdef RAND_DELAY_EN
      lfsr_q     <= 8'hA5;
      hold_q     <= 2'd0;
      gap_q      <= 2'd0;
`endif
    end else begin
`ifdef RAND_DELAY_EN
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
`endif
      case (state_q)
        S_IDLE: begin
`ifdef RAND_DELAY_EN
          if (hold_q != 2'd0) hold_q <= hold_q - 2'd1;
`endif
          if (ar_hs_w) begin
            cur_addr_q <= i_axi_araddr;
            len_q      <= i_axi_arlen;
            rid_q      <= i_axi_arid;
            bad_q      <= (i_axi_arsize != 3'b010) || i_axi_arburst[1];
            fixed_q    <= (i_axi_arburst == 2'b00);
            beat_cnt_q <= 8'h0;
            wait_cnt_q <= 8'(LATENCY - 1);
            state_q    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wait_cnt_q != 8'd0) wait_cnt_q <= wait_cnt_q - 8'd1;
        end
        S_DATA: begin
          if (rvalid_q && i_axi_rready) begin
            if (rlast_q) begin
              rvalid_q <= 1'b0;
              rlast_q  <= 1'b0;
              state_q  <= S_IDLE;
`ifdef RAND_DELAY_EN
              hold_q   <= lfsr_q[1:0];
`endif
            end
`ifdef RAND_DELAY_EN
            else if (lfsr_q[1:0] != 2'd0) begin
              rvalid_q <= 1'b0;
              gap_q    <= lfsr_q[1:0] - 2'd1;
              state_q  <= S_GAP;
            end
`endif
          end
        end
`ifdef RAND_DELAY_EN
        S_GAP: begin
          if (gap_q != 2'd0) gap_q <= gap_q - 2'd1;
        end
`endif
        default: state_q <= S_IDLE;
      endcase
      // Presenting a beat overrides whatever the state decode above chose.
      if (load_w) begin
        rvalid_q   <= 1'b1;
        rdata_q    <= beat_data_w;
        rresp_q    <= beat_resp_w;
        rlast_q    <= (beat_cnt_q == len_q);
        cur_addr_q <= next_addr_w;
        beat_cnt_q <= beat_cnt_q + 8'd1;
        state_q    <= S_DATA;
      end
    end
  end

  assign o_axi_rvalid = rvalid_q;
  assign o_axi_rlast  = rlast_q;
  assign o_axi_rdata  = rdata_q;
  assign o_axi_rresp  = rresp_q;
  assign o_axi_rid    = rid_q;
  assign o_dbg_state  = state_q;
endmodule
